// File: rtl/if_icache_if.sv
// Bus bundle for the LC-3b instruction cache.
// Carries the fetch-side request/response and the physical-memory line-fill port.
// The slave view belongs to the cache. The master view belongs to its environment.
interface if_icache_if;
  logic [15:0]  inst_addr;
  logic         inst_read;
  logic [15:0]  inst_rdata;
  logic         inst_resp;
  logic         inv;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  inst_addr, inst_read, inv, pmem_rdata, pmem_resp,
    output inst_rdata, inst_resp, pmem_address, pmem_read
  );

  modport master (
    output inst_addr, inst_read, inv, pmem_rdata, pmem_resp,
    input  inst_rdata, inst_resp, pmem_address, pmem_read
  );
endinterface

// File: rtl/if_icache.sv
// Direct-mapped, read-only instruction cache sitting in front of the LC-3b fetch stage.
// A hit answers in the same cycle. A miss stalls fetch while a 128-bit line is read
// from physical memory.
// Optional hit/miss counters are enabled by defining IF_ICACHE_PERF_EN.
module if_icache #(
  parameter int NUM_SETS = 8
) (
  input  logic        clk,
  input  logic        reset,
  if_icache_if.slave  bus
`ifdef IF_ICACHE_PERF_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 12 - IW;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e              state_q, state_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TW-1:0]       tag_q  [NUM_SETS];
  logic [127:0]        data_q [NUM_SETS];
  logic [15:0]         miss_addr_q, miss_addr_d;
  logic                inv_pending_q, inv_pending_d;

  logic [2:0]          req_off;
  logic [IW-1:0]       req_idx;
  logic [TW-1:0]       req_tag;
  logic [IW-1:0]       fill_idx;
  logic                hit;
  logic                fill_en;
  logic                unused_addr_bit;

  assign req_off         = bus.inst_addr[3:1];
  assign req_idx         = bus.inst_addr[IW+3:4];
  assign req_tag         = bus.inst_addr[15:IW+4];
  assign fill_idx        = miss_addr_q[IW+3:4];
  assign unused_addr_bit = bus.inst_addr[0];

  // State, valid bits, captured miss address and deferred invalidate; all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      valid_q       <= '0;
      miss_addr_q   <= '0;
      inv_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      miss_addr_q   <= miss_addr_d;
      inv_pending_q <= inv_pending_d;
    end
  end

  // Tag and data storage is written only by a completed fill. A reset in the same cycle blocks the write.
  always_ff @(posedge clk) begin
    if (fill_en && !reset) begin
      tag_q[fill_idx]  <= miss_addr_q[15:IW+4];
      data_q[fill_idx] <= bus.pmem_rdata;
    end
  end

  // Lookup, miss detection, fill sequencing and invalidate handling.
  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    miss_addr_d       = miss_addr_q;
    inv_pending_d     = inv_pending_q;
    hit               = 1'b0;
    fill_en           = 1'b0;
    bus.inst_resp     = 1'b0;
    bus.inst_rdata    = 16'h0000;
    bus.pmem_read     = 1'b0;
    bus.pmem_address  = 16'h0000;

    unique case (state_q)
      IDLE: begin
        inv_pending_d = 1'b0;
        hit = bus.inst_read && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        if (hit) begin
          bus.inst_resp  = 1'b1;
          bus.inst_rdata = data_q[req_idx][{req_off, 4'b0000} +: 16];
        end else if (bus.inst_read) begin
          state_d     = FETCH;
          miss_addr_d = {bus.inst_addr[15:4], 4'b0000};
        end
        if (bus.inv) begin
          valid_d = '0;
        end
      end
      FETCH: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = miss_addr_q;
        if (bus.pmem_resp) begin
          fill_en       = 1'b1;
          state_d       = IDLE;
          inv_pending_d = 1'b0;
          if (inv_pending_q || bus.inv) begin
            valid_d = '0;
          end else begin
            valid_d[fill_idx] = 1'b1;
          end
        end else if (bus.inv) begin
          inv_pending_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef IF_ICACHE_PERF_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;

  // Saturating hit/miss counters. Only reset clears them; invalidate leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
    end else begin
      if (hit && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'h0001;
      end
      if ((state_q == IDLE) && (state_d == FETCH) && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'h0001;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_if_icache.sv
// Self-checking bench for if_icache. It runs directed scenarios and then randomized traffic.
// A behavioural model of the direct-mapped cache predicts the results, and a random memory image supplies the line data.
module tb_if_icache;

  localparam int NUM_SETS = 8;
  localparam int IW       = 3;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] memImage [0:32767];
  bit          mValid   [NUM_SETS];
  int unsigned mTag     [NUM_SETS];

`ifdef IF_ICACHE_PERF_EN
  logic [15:0] hitCount;
  logic [15:0] missCount;
`endif

  if_icache_if bus ();

  if_icache #(.NUM_SETS(NUM_SETS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IF_ICACHE_PERF_EN
    ,
    .hit_count  (hitCount),
    .miss_count (missCount)
`endif
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int setOf(input logic [15:0] a);
    return (int'(a) / 16) % NUM_SETS;
  endfunction

  function automatic int unsigned tagOf(input logic [15:0] a);
    return int'(a) / (16 * NUM_SETS);
  endfunction

  function automatic bit modelHit(input logic [15:0] a);
    return mValid[setOf(a)] && (mTag[setOf(a)] == tagOf(a));
  endfunction

  function automatic void modelFill(input logic [15:0] a);
    mValid[setOf(a)] = 1'b1;
    mTag[setOf(a)]   = tagOf(a);
  endfunction

  function automatic void modelClear();
    for (int s = 0; s < NUM_SETS; s++) mValid[s] = 1'b0;
  endfunction

  function automatic logic [15:0] wordAt(input logic [15:0] a);
    return memImage[int'(a) / 2];
  endfunction

  function automatic logic [127:0] lineData(input logic [15:0] a);
    logic [127:0] d;
    int base;
    base = (int'(a) / 16) * 8;
    for (int w = 0; w < 8; w++) d[16*w +: 16] = memImage[base + w];
    return d;
  endfunction

  task automatic idleInputs();
    bus.inst_read  = 1'b0;
    bus.inv        = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  // Drives a known miss through the fill with the given memory latency. Does no checking.
  task automatic fillLine(input logic [15:0] a, input int latency);
    bus.inst_addr = a;
    bus.inst_read = 1'b1;
    tick();
    repeat (latency - 1) tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(a);
    tick();
    bus.pmem_resp  = 1'b0;
    modelFill(a);
  endtask

  task automatic test_reset();
    idleInputs();
    bus.inst_addr = 16'h0000;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    modelClear();
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_resp: got %b expected 0", bus.inst_resp); end
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("[TB] FAIL reset_pmem_read: got %b expected 0", bus.pmem_read); end
    checks++; if (bus.pmem_address !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pmem_address: got %h expected 0000", bus.pmem_address); end
    checks++; if (bus.inst_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_inst_rdata: got %h expected 0000", bus.inst_rdata); end
    tick();
  endtask

  task automatic test_first_miss();
    bus.inst_addr = 16'h0000;
    bus.inst_read = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL first_miss_resp: got %b expected 0", bus.inst_resp); end
    tick();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = lineData(16'h0000);
      end
      @(negedge clk);
      checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("[TB] FAIL first_fetch_pmem_read c%0d: got %b expected 1", c, bus.pmem_read); end
      checks++; if (bus.pmem_address !== 16'h0000) begin errors++; $display("[TB] FAIL first_fetch_address c%0d: got %h expected 0000", c, bus.pmem_address); end
      checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL first_fetch_resp c%0d: got %b expected 0", c, bus.inst_resp); end
      tick();
      bus.pmem_resp = 1'b0;
    end
    modelFill(16'h0000);
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b1) begin errors++; $display("[TB] FAIL first_hit_resp: got %b expected 1", bus.inst_resp); end
    checks++; if (bus.inst_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL first_hit_rdata: got %h expected 1234", bus.inst_rdata); end
    tick();
  endtask

  task automatic test_sequential_hits();
    for (int w = 1; w < 8; w++) begin
      bus.inst_addr = 16'(w * 2);
      bus.inst_read = 1'b1;
      @(negedge clk);
      checks++; if (bus.inst_resp !== 1'b1) begin errors++; $display("[TB] FAIL seq_hit_resp w%0d: got %b expected 1", w, bus.inst_resp); end
      checks++; if (bus.inst_rdata !== memImage[w]) begin errors++; $display("[TB] FAIL seq_hit_rdata w%0d: got %h expected %h", w, bus.inst_rdata, memImage[w]); end
      checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("[TB] FAIL seq_hit_pmem_read w%0d: got %b expected 0", w, bus.pmem_read); end
      tick();
    end
    bus.inst_read = 1'b0;
  endtask

  task automatic test_eviction();
    fillLine(16'h0010, 2);
    bus.inst_addr = 16'h0090;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL evict_conflict_resp: got %b expected 0", bus.inst_resp); end
    tick();
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("[TB] FAIL evict_pmem_read: got %b expected 1", bus.pmem_read); end
    checks++; if (bus.pmem_address !== 16'h0090) begin errors++; $display("[TB] FAIL evict_address: got %h expected 0090", bus.pmem_address); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0090);
    tick();
    bus.pmem_resp = 1'b0;
    modelFill(16'h0090);
    @(negedge clk);
    checks++; if (bus.inst_rdata !== wordAt(16'h0090) || bus.inst_resp !== 1'b1) begin errors++; $display("[TB] FAIL evict_new_hit: got resp %b data %h expected resp 1 data %h", bus.inst_resp, bus.inst_rdata, wordAt(16'h0090)); end
    tick();
    bus.inst_addr = 16'h0010;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL evict_old_misses: got %b expected 0", bus.inst_resp); end
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0010);
    tick();
    bus.pmem_resp = 1'b0;
    bus.inst_read = 1'b0;
    modelFill(16'h0010);
  endtask

  task automatic test_inv();
    if (!modelHit(16'h0000)) fillLine(16'h0000, 2);
    bus.inst_addr = 16'h0000;
    bus.inst_read = 1'b1;
    bus.inv       = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b1) begin errors++; $display("[TB] FAIL inv_idle_same_cycle_hit: got %b expected 1", bus.inst_resp); end
    tick();
    bus.inv = 1'b0;
    modelClear();
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL inv_idle_refetch_miss: got %b expected 0", bus.inst_resp); end
    tick();
    bus.inv = 1'b1;
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("[TB] FAIL inv_fetch_pmem_read: got %b expected 1", bus.pmem_read); end
    tick();
    bus.inv        = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0000);
    tick();
    bus.pmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL inv_fetch_line_invalid: got %b expected 0", bus.inst_resp); end
    tick();
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0000) begin errors++; $display("[TB] FAIL inv_fetch_refetch: got read %b addr %h expected read 1 addr 0000", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0000);
    tick();
    bus.pmem_resp = 1'b0;
    modelFill(16'h0000);
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b1 || bus.inst_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL inv_refill_hit: got resp %b data %h expected resp 1 data 1234", bus.inst_resp, bus.inst_rdata); end
    tick();
    bus.inst_read = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    bus.inst_addr = 16'h0230;
    bus.inst_read = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_initial_miss: got %b expected 0", bus.inst_resp); end
    tick();
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("[TB] FAIL rst_fetch_pmem_read: got %b expected 1", bus.pmem_read); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelClear();
    bus.inst_read  = 1'b0;
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0230);
    @(negedge clk);
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_read_dropped: got %b expected 0", bus.pmem_read); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.inst_read = 1'b1;
    @(negedge clk);
    checks++; if (bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL rst_fetch_stale_ignored: got %b expected 0", bus.inst_resp); end
    tick();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = lineData(16'h0230);
    tick();
    bus.pmem_resp = 1'b0;
    bus.inst_read = 1'b0;
    modelFill(16'h0230);
  endtask

  task automatic test_random();
    logic [15:0] addr;
    logic [15:0] missAddr;
    bit          expHit;
    bit          idleInv;
    bit          fetchInv;
    int          latency;
    for (int it = 0; it < 300; it++) begin
      addr          = 16'(($urandom_range(0, 31) << 4) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
      bus.inst_addr = addr;
      bus.inst_read = ($urandom_range(0, 4) != 0);
      idleInv       = ($urandom_range(0, 11) == 0);
      bus.inv       = idleInv;
      if (!bus.inst_read) begin
        bus.pmem_resp  = $urandom_range(0, 1);
        bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        checks++; if (bus.inst_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle it%0d: got resp %b read %b expected 0 0", it, bus.inst_resp, bus.pmem_read); end
        tick();
        bus.pmem_resp = 1'b0;
        bus.inv       = 1'b0;
        if (idleInv) modelClear();
        continue;
      end
      expHit = modelHit(addr);
      @(negedge clk);
      checks++; if (bus.inst_resp !== expHit) begin errors++; $display("[TB] FAIL rand_resp it%0d addr %h: got %b expected %b", it, addr, bus.inst_resp, expHit); end
      if (expHit) begin
        checks++; if (bus.inst_rdata !== wordAt(addr)) begin errors++; $display("[TB] FAIL rand_rdata it%0d addr %h: got %h expected %h", it, addr, bus.inst_rdata, wordAt(addr)); end
      end
      tick();
      bus.inv = 1'b0;
      if (idleInv) modelClear();
      if (!expHit) begin
        missAddr = {addr[15:4], 4'h0};
        latency  = $urandom_range(1, 4);
        fetchInv = (latency > 1) && ($urandom_range(0, 4) == 0);
        for (int c = 0; c < latency; c++) begin
          if (c == 0 && fetchInv) bus.inv = 1'b1;
          if ($urandom_range(0, 3) == 0) bus.inst_addr = 16'($urandom);
          if (c == latency - 1) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = lineData(missAddr);
          end
          @(negedge clk);
          checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== missAddr || bus.inst_resp !== 1'b0) begin errors++; $display("[TB] FAIL rand_fetch it%0d c%0d: got read %b addr %h resp %b expected 1 %h 0", it, c, bus.pmem_read, bus.pmem_address, bus.inst_resp, missAddr); end
          tick();
          bus.inv       = 1'b0;
          bus.pmem_resp = 1'b0;
        end
        if (fetchInv) modelClear();
        else modelFill(missAddr);
      end
    end
    bus.inst_read = 1'b0;
  endtask

`ifdef IF_ICACHE_PERF_EN
  task automatic test_perf();
    fillLine(16'h0040, 2);
    repeat (7) tick();
    bus.inst_read = 1'b0;
    @(negedge clk);
    checks++; if (missCount !== 16'd1) begin errors++; $display("[TB] FAIL perf_miss_count: got %0d expected 1", missCount); end
    checks++; if (hitCount !== 16'd7) begin errors++; $display("[TB] FAIL perf_hit_count: got %0d expected 7", hitCount); end
    tick();
    bus.inst_read = 1'b1;
    repeat (65530) tick();
    bus.inst_read = 1'b0;
    @(negedge clk);
    checks++; if (hitCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_hit_saturate: got %h expected ffff", hitCount); end
    tick();
    bus.inst_read = 1'b1;
    tick();
    bus.inst_read = 1'b0;
    @(negedge clk);
    checks++; if (hitCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL perf_hit_stays_saturated: got %h expected ffff", hitCount); end
    tick();
  endtask
`endif

  // Runs every scenario in order, then prints the summary.
  initial begin
    for (int i = 0; i < 32768; i++) memImage[i] = 16'($urandom);
    memImage[0] = 16'h1234;
    bus.inst_addr = 16'h0000;
    idleInputs();
    reset = 1'b1;
    test_reset();
    test_first_miss();
    test_sequential_hits();
    test_eviction();
    test_inv();
    test_reset_mid_fetch();
    test_random();
`ifdef IF_ICACHE_PERF_EN
    test_reset();
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
